// File: rtl/sargantana_icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sargantana_icache_pkg
// Description : Shared icache geometry and tag-controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sargantana_icache_pkg;

    localparam int ICACHE_N_WAY     = 4;
    localparam int TAG_WIDHT        = 27;
    localparam int ADDR_WIDHT       = 9;
    localparam int ICACHE_IDX_WIDHT = ADDR_WIDHT - 2;
    localparam int ICACHE_WAY_IDX   = $clog2(ICACHE_N_WAY);

    typedef enum logic [1:0] {
        ITAG_IDLE    = 2'd0,
        ITAG_COMPARE = 2'd1,
        ITAG_MISS    = 2'd2
    } itag_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/sargantana_itag_victim_sel.sv
`default_nettype none
// ============================================================================
// Module      : sargantana_itag_victim_sel
// Description : Picks the lowest invalid way, else the round-robin way.
// Revision    : 1.0 - initial release
// ============================================================================
module sargantana_itag_victim_sel
    import sargantana_icache_pkg::*;
(
    input  logic [ICACHE_N_WAY-1:0]   vbit_i,
    input  logic [ICACHE_WAY_IDX-1:0] rr_i,
    output logic [ICACHE_N_WAY-1:0]   victim_o,
    output logic                      all_valid_o
);

    localparam logic [ICACHE_N_WAY-1:0] c_one = ICACHE_N_WAY'(1);

    logic [ICACHE_N_WAY-1:0] w_first_free;
    logic [ICACHE_N_WAY-1:0] w_rr_onehot;

    // Adding one ripples through the low run of ones, isolating the first zero.
    assign w_first_free = ~vbit_i & (vbit_i + c_one);
    assign w_rr_onehot  = c_one << rr_i;
    assign all_valid_o  = &vbit_i;
    assign victim_o     = all_valid_o ? w_rr_onehot : w_first_free;

endmodule
`default_nettype wire

// File: rtl/sargantana_itag_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sargantana_itag_lookup_ctrl
// Description : Icache tag-array lookup, hit/miss compare and refill tag write.
// Revision    : 1.0 - initial release
// ============================================================================
module sargantana_itag_lookup_ctrl
    import sargantana_icache_pkg::*;
(
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic                                flush_i,
    input  logic                                lkp_valid_i,
    output logic                                lkp_ready_o,
    input  logic [ICACHE_IDX_WIDHT-1:0]         lkp_idx_i,
    input  logic [TAG_WIDHT-1:0]                lkp_tag_i,
    output logic                                rsp_valid_o,
    output logic                                rsp_hit_o,
    output logic [ICACHE_N_WAY-1:0]             rsp_way_o,
    output logic                                rsp_multihit_o,
    output logic [ICACHE_N_WAY-1:0]             rsp_victim_o,
    input  logic                                refill_valid_i,
    output logic                                refill_done_o,
    output logic [ICACHE_N_WAY-1:0]             tag_req_o,
    output logic                                tag_we_o,
    output logic                                tag_vbit_o,
    output logic                                tag_flush_o,
    output logic [TAG_WIDHT-1:0]                tag_data_o,
    output logic [ICACHE_IDX_WIDHT-1:0]         tag_addr_o,
    input  logic [ICACHE_N_WAY*TAG_WIDHT-1:0]   tag_way_i,
    input  logic [ICACHE_N_WAY-1:0]             vbit_i
);

    localparam logic [ICACHE_N_WAY-1:0] c_one = ICACHE_N_WAY'(1);

    itag_ctrl_state_t              r_state;
    itag_ctrl_state_t              w_next_state;
    logic [ICACHE_IDX_WIDHT-1:0]   r_idx;
    logic [TAG_WIDHT-1:0]          r_tag;
    logic [ICACHE_N_WAY-1:0]       r_victim;
    logic                          r_victim_rr;
    logic [ICACHE_WAY_IDX-1:0]     r_rr;

    logic [ICACHE_N_WAY-1:0]       w_match;
    logic                          w_multihit;
    logic [ICACHE_N_WAY-1:0]       w_victim;
    logic                          w_all_valid;
    logic                          w_accept;
    logic                          w_miss;

    for (genvar w = 0; w < ICACHE_N_WAY; w++) begin : g_match
        assign w_match[w] = vbit_i[w] && (tag_way_i[w*TAG_WIDHT +: TAG_WIDHT] == r_tag);
    end

    assign w_multihit = |(w_match & (w_match - c_one));
    assign w_accept   = lkp_valid_i & lkp_ready_o;
    assign w_miss     = rsp_valid_o & ~rsp_hit_o;
    assign tag_flush_o = flush_i;

    sargantana_itag_victim_sel u_victim_sel (
        .vbit_i      (vbit_i),
        .rr_i        (r_rr),
        .victim_o    (w_victim),
        .all_valid_o (w_all_valid)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ITAG_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush_i) begin
            w_next_state = ITAG_IDLE;
        end else begin
            case (r_state)
                ITAG_IDLE:    if (w_accept) w_next_state = ITAG_COMPARE;
                ITAG_COMPARE: w_next_state = (|w_match) ? ITAG_IDLE : ITAG_MISS;
                ITAG_MISS:    if (refill_valid_i) w_next_state = ITAG_IDLE;
                default:      w_next_state = ITAG_IDLE;
            endcase
        end
    end

    always_comb begin
        lkp_ready_o    = 1'b0;
        rsp_valid_o    = 1'b0;
        rsp_hit_o      = 1'b0;
        rsp_way_o      = '0;
        rsp_multihit_o = 1'b0;
        rsp_victim_o   = '0;
        refill_done_o  = 1'b0;
        tag_req_o      = '0;
        tag_we_o       = 1'b0;
        tag_vbit_o     = 1'b0;
        tag_data_o     = '0;
        tag_addr_o     = '0;
        // Flush and reset silence every request/response output.
        if (rstn_i && !flush_i) begin
            case (r_state)
                ITAG_IDLE: begin
                    lkp_ready_o = 1'b1;
                    if (lkp_valid_i) begin
                        tag_req_o  = '1;
                        tag_addr_o = lkp_idx_i;
                    end
                end
                ITAG_COMPARE: begin
                    rsp_valid_o    = 1'b1;
                    rsp_hit_o      = |w_match;
                    rsp_way_o      = w_match;
                    rsp_multihit_o = w_multihit;
                    if (!(|w_match)) rsp_victim_o = w_victim;
                end
                ITAG_MISS: begin
                    if (refill_valid_i) begin
                        tag_req_o     = r_victim;
                        tag_we_o      = 1'b1;
                        tag_vbit_o    = 1'b1;
                        tag_data_o    = r_tag;
                        tag_addr_o    = r_idx;
                        refill_done_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_idx       <= '0;
            r_tag       <= '0;
            r_victim    <= '0;
            r_victim_rr <= 1'b0;
            r_rr        <= '0;
        end else if (flush_i) begin
            r_idx       <= '0;
            r_tag       <= '0;
            r_victim    <= '0;
            r_victim_rr <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx <= lkp_idx_i;
                r_tag <= lkp_tag_i;
            end
            if (w_miss) begin
                r_victim    <= w_victim;
                r_victim_rr <= w_all_valid;
            end
            // Only a round-robin eviction advances the pointer.
            if (refill_done_o && r_victim_rr) begin
                r_rr <= r_rr + ICACHE_WAY_IDX'(1);
            end
        end
    end

endmodule
`default_nettype wire
